// File: rtl/ram_dma_if.sv
// Control and RAM-port bundle for the block copy/fill engine.
// master = CPU plus RAM side, slave = the engine itself.
interface ram_dma_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_val;
    logic          hold;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   remain;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;

    modport master (
        output start, mode, src, dst, len, fill_val, hold, abort, ram_dout,
        input  busy, done, aborted, remain,
        input  ram_ad, ram_din, ram_ce, ram_oce, ram_wre
    );

    modport slave (
        input  start, mode, src, dst, len, fill_val, hold, abort, ram_dout,
        output busy, done, aborted, remain,
        output ram_ad, ram_din, ram_ce, ram_oce, ram_wre
    );
endinterface

// File: rtl/ram_dma.sv
// Byte-serial block copy / block fill engine on one port of the work RAM.
// Ascending order; copy takes RD+WR per byte, fill one WR per byte.
module ram_dma #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    ram_dma_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [AW-1:0] dp_q, dp_d;
    logic [AW:0]   rem_q, rem_d;
    logic          md_q, md_d;
    logic [DW-1:0] fv_q, fv_d;
    logic          ab_q, ab_d;
    logic          done_q, done_d;
    logic          ce, wre;
    logic [AW-1:0] ad;
    logic [DW-1:0] din;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        dp_d    = dp_q;
        rem_d   = rem_q;
        md_d    = md_q;
        fv_d    = fv_q;
        ab_d    = ab_q;
        done_d  = 1'b0;
        ce      = 1'b0;
        wre     = 1'b0;
        ad      = '0;
        din     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sp_d  = bus.src;
                    dp_d  = bus.dst;
                    rem_d = bus.len;
                    md_d  = bus.mode;
                    fv_d  = bus.fill_val;
                    ab_d  = 1'b0;
                    if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = bus.mode ? WR : RD;
                    end
                end
            end
            RD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    ab_d    = 1'b1;
                    done_d  = 1'b1;
                end else if (!bus.hold) begin
                    ce      = 1'b1;
                    ad      = sp_q;
                    sp_d    = sp_q + AW'(1);
                    state_d = WR;
                end
            end
            WR: begin
                // a copy write must consume the byte already read
                if (md_q && bus.abort) begin
                    state_d = IDLE;
                    ab_d    = 1'b1;
                    done_d  = 1'b1;
                end else if (!md_q || !bus.hold) begin
                    ce    = 1'b1;
                    wre   = 1'b1;
                    ad    = dp_q;
                    din   = md_q ? fv_q : bus.ram_dout;
                    dp_d  = dp_q + AW'(1);
                    rem_d = rem_q - (AW+1)'(1);
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (!md_q) begin
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sp_q    <= '0;
            dp_q    <= '0;
            rem_q   <= '0;
            md_q    <= 1'b0;
            fv_q    <= '0;
            ab_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dp_q    <= dp_d;
            rem_q   <= rem_d;
            md_q    <= md_d;
            fv_q    <= fv_d;
            ab_q    <= ab_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.aborted = ab_q;
    assign bus.remain  = rem_q;
    assign bus.ram_ad  = ad;
    assign bus.ram_din = din;
    assign bus.ram_ce  = ce;
    assign bus.ram_oce = ce;
    assign bus.ram_wre = wre;
endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: table vectors, random jobs against a byte-order
// memory model, and hand sequences for hold, abort and reset.
module tb_ram_dma;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    typedef struct {
        bit mode;
        int src;
        int dst;
        int len;
        int fv;
        int exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_dma_if #(.AW(AW), .DW(DW)) bus ();

    ram_dma #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [7:0]    mem     [N];
    logic [7:0]    ref_mem [N];
    logic [7:0]    rdout;
    logic          pre_we;
    logic [AW-1:0] pre_ad;
    logic [7:0]    pre_d;

    // bench-side RAM with registered read, plus a preload port
    always @(posedge clk) begin
        if (pre_we) mem[pre_ad] <= pre_d;
        else if (bus.ram_ce) begin
            if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
            else rdout <= mem[bus.ram_ad];
        end
    end
    assign bus.ram_dout = rdout;

    int cyc = 0, wr_cnt = 0, ce_cnt = 0, busy_cnt = 0, done_cnt = 0;
    int done_busy = 0, hold_ce = 0, last_wr = 0, done_cyc = 0, start_cyc = 0;
    logic [AW-1:0] wr_q [$];
    int wc_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_ce) ce_cnt <= ce_cnt + 1;
        if (bus.ram_ce && bus.ram_wre) begin
            wr_cnt  <= wr_cnt + 1;
            last_wr <= cyc;
            wr_q.push_back(bus.ram_ad);
            wc_q.push_back(cyc);
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.done && bus.busy) done_busy <= done_busy + 1;
        if (bus.hold && bus.ram_ce) hold_ce <= hold_ce + 1;
        if (bus.start && !bus.busy) start_cyc <= cyc;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        pre_ad = a[AW-1:0];
        pre_d  = d[7:0];
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[a & (N-1)] = d[7:0];
    endtask

    // forward byte order: each byte read from the model before written
    task automatic model(input bit m, input int s, input int d,
                         input int l, input int f);
        for (int i = 0; i < l; i++)
            ref_mem[(d + i) % N] = m ? f[7:0] : ref_mem[(s + i) % N];
    endtask

    function automatic int mem_diff();
        int bad = 0;
        for (int i = 0; i < N; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        return bad;
    endfunction

    task automatic kick(input bit m, input int s, input int d, input int l,
                        input int f, input bit ab);
        @(negedge clk);
        bus.mode     = m;
        bus.src      = s[AW-1:0];
        bus.dst      = d[AW-1:0];
        bus.len      = l[AW:0];
        bus.fill_val = f[7:0];
        bus.abort    = ab;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_checks(input string nm, input int b0, input int w0,
                                 input int c0, input int d0, input int db0,
                                 input int exp_busy, input int exp_wr,
                                 input int exp_ce, input int exp_rem,
                                 input int exp_ab, input int budget);
        bit ok;
        wait_done(budget, ok);
        chk({nm, "_done_seen"}, int'(ok), 1);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_busy_cycles"}, busy_cnt - b0, exp_busy);
        chk({nm, "_writes"}, wr_cnt - w0, exp_wr);
        chk({nm, "_ce_cycles"}, ce_cnt - c0, exp_ce);
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        chk({nm, "_done_busy"}, done_busy - db0, 0);
        chk({nm, "_remain"}, int'(bus.remain), exp_rem);
        chk({nm, "_aborted"}, int'(bus.aborted), exp_ab);
        chk({nm, "_mem"}, mem_diff(), 0);
    endtask

    task automatic run_job(input string nm, input bit m, input int s,
                           input int d, input int l, input int f,
                           input int exp_busy);
        int b0 = busy_cnt, w0 = wr_cnt, c0 = ce_cnt;
        int d0 = done_cnt, db0 = done_busy;
        model(m, s, d, l, f);
        kick(m, s, d, l, f, 1'b0);
        finish_checks(nm, b0, w0, c0, d0, db0, exp_busy, l, exp_busy,
                      0, 0, 2 * l + 20);
        if (l > 0) chk({nm, "_done_lat"}, done_cyc, last_wr + 1);
        else chk({nm, "_done_lat"}, done_cyc, start_cyc + 1);
    endtask

    vec_t vt [5];

    initial begin
        int b0, w0, c0, d0, db0, base, m, s, d, l, f;
        int wexp [4];
        vt[0] = '{1'b0, 'h0100, 'h2000, 4, 0, 8};
        vt[1] = '{1'b0, 'h0010, 'h0011, 4, 0, 8};
        vt[2] = '{1'b1, 'h0040, 'h0050, 0, 'hEE, 0};
        vt[3] = '{1'b0, 'h3FFF, 'h0300, 1, 0, 2};
        vt[4] = '{1'b1, 'h0400, 'h0410, 6, 'h5C, 6};
        wexp = '{'h3FFE, 'h3FFF, 'h0000, 'h0001};

        pre_we = 1'b0; pre_ad = '0; pre_d = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_val = '0; bus.hold = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_aborted", int'(bus.aborted), 0);
        chk("rst_remain", int'(bus.remain), 0);
        chk("rst_ce", int'(bus.ram_ce), 0);
        chk("rst_oce", int'(bus.ram_oce), 0);
        chk("rst_wre", int'(bus.ram_wre), 0);
        chk("rst_ad", int'(bus.ram_ad), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N; i++) poke(i, int'($urandom_range(0, 255)));
        poke('h0100, 'h11); poke('h0101, 'h22);
        poke('h0102, 'h33); poke('h0103, 'h44);
        poke('h0010, 'h5A);

        for (int i = 0; i < 5; i++)
            run_job($sformatf("vec%0d", i), vt[i].mode, vt[i].src,
                    vt[i].dst, vt[i].len, vt[i].fv, vt[i].exp_busy);
        chk("copy_b0", int'(mem['h2000]), 'h11);
        chk("copy_b3", int'(mem['h2003]), 'h44);
        chk("ovl_b4", int'(mem['h0014]), 'h5A);

        base = wr_q.size();
        run_job("wrap", 1'b1, 'h3FFE, 'h3FFE, 4, 'hA5, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_ad%0d", i), int'(wr_q[base + i]), wexp[i]);
        chk("wrap_consec", wc_q[base + 3] - wc_q[base], 3);

        // hold for 5 cycles starting at the second RD
        b0 = busy_cnt; w0 = wr_cnt; c0 = ce_cnt; d0 = done_cnt;
        db0 = done_busy; base = hold_ce;
        model(1'b0, 'h0200, 'h0220, 3, 0);
        kick(1'b0, 'h0200, 'h0220, 3, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.hold = 1'b1;
        repeat (5) @(negedge clk);
        bus.hold = 1'b0;
        finish_checks("hold", b0, w0, c0, d0, db0, 11, 3, 6, 0, 0, 40);
        chk("hold_ce", hold_ce - base, 0);

        // fill abort after three writes
        b0 = busy_cnt; w0 = wr_cnt; c0 = ce_cnt; d0 = done_cnt;
        db0 = done_busy;
        model(1'b1, 0, 'h3000, 3, 'h3C);
        kick(1'b1, 0, 'h3000, 10, 'h3C, 1'b0);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        finish_checks("abort", b0, w0, c0, d0, db0, 4, 3, 3, 7, 1, 20);
        run_job("post_abort", 1'b0, 'h0500, 'h0508, 0, 0, 0);

        // abort together with start in IDLE: start wins
        b0 = busy_cnt; w0 = wr_cnt; c0 = ce_cnt; d0 = done_cnt;
        db0 = done_busy;
        model(1'b0, 'h0700, 'h0710, 2, 0);
        kick(1'b0, 'h0700, 'h0710, 2, 0, 1'b1);
        finish_checks("start_abort", b0, w0, c0, d0, db0, 4, 2, 4, 0, 0, 20);

        // second start while busy must be ignored
        b0 = busy_cnt; w0 = wr_cnt; c0 = ce_cnt; d0 = done_cnt;
        db0 = done_busy;
        model(1'b1, 0, 'h0500, 8, 'h77);
        kick(1'b1, 0, 'h0500, 8, 'h77, 1'b0);
        @(negedge clk);
        kick(1'b1, 0, 'h0600, 5, 'h99, 1'b0);
        finish_checks("busy_start", b0, w0, c0, d0, db0, 8, 8, 8, 0, 0, 30);

        for (int k = 0; k < 25; k++) begin
            m = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, N - 1));
            d = int'($urandom_range(0, N - 1));
            l = int'($urandom_range(0, 48));
            f = int'($urandom_range(0, 255));
            run_job($sformatf("rnd%0d", k), m[0], s, d, l, f,
                    m[0] ? l : 2 * l);
        end
        run_job("full", 1'b1, 0, int'($urandom_range(0, N - 1)), N,
                int'($urandom_range(0, 255)), N);

        // reset in the middle of a copy
        d0 = done_cnt;
        kick(1'b0, 'h1000, 'h1800, 20, 0, 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_ce", int'(bus.ram_ce), 0);
        chk("mrst_wre", int'(bus.ram_wre), 0);
        chk("mrst_ad", int'(bus.ram_ad), 0);
        chk("mrst_din", int'(bus.ram_din), 0);
        chk("mrst_remain", int'(bus.remain), 0);
        chk("mrst_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_no_done", done_cnt - d0, 0);
        chk("mrst_idle", int'(bus.busy), 0);
        for (int i = 0; i < N; i++) ref_mem[i] = mem[i];
        run_job("after_rst", 1'b0, 'h1000, 'h2800, 5, 0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
